uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver; the receive-side counterpart of uart_tx. Format is 8N1, LSB first, line idle high.
- Synchronises the asynchronous pmod input to i_clock, finds the start bit and samples each bit at its centre.
- Presents each received byte as a one-cycle valid strobe.
- Feeds loopback/echo logic and ROM-driven test tops in the same clock domain as uart_tx.

Parameters:
- CLKS_PER_BIT, 868, i_clock cycles per bit (100 MHz / 115200). Must be >= 4.
- SYNC_STAGES, 2, number of flops in the input synchroniser. Must be >= 2.

Ports:
- i_clock  in  1  system clock (clk_100mhz at top)
- i_reset  in  1  synchronous reset, active-high
- i_signal  in  1  asynchronous serial line, idle high
- o_data  out  8  last correctly received byte; held until the next good byte
- o_valid  out  1  one-cycle strobe: o_data updated this cycle
- o_frame_err  out  1  one-cycle strobe: stop bit sampled low
- o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset, on a clock edge with i_reset=1:
  - o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - Synchroniser flops preset to 1; FSM to IDLE; bit counter and tick counter to 0.
  - Reset mid-frame abandons the byte with no strobe.
- Sampling: the FSM uses only the last synchroniser stage (rx_s). Raw i_signal is never sampled by the FSM.
- Tick counter width: $clog2(CLKS_PER_BIT). Cleared on every state entry.
- IDLE:
  - Entered when rx_s==0: go to START, clear the tick counter.
  - Otherwise remain in IDLE.
- START:
  - At tick CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - rx_s==0: go to DATA, clear the tick counter and bit index.
  - rx_s==1: treat as a glitch and return to IDLE with no strobe.
- DATA:
  - At tick CLKS_PER_BIT-1, shift rx_s into shift[7], shifting right, so the result is LSB first.
  - Increment the bit index; after the 8th sample go to STOP (or PARITY when the feature is enabled).
- STOP:
  - At tick CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: o_data<=shift, o_valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: o_frame_err=1 for one cycle, o_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Remain until rx_s==1, then go to IDLE. This covers a break or held-low line.
  - o_busy stays high in this state.
- Latency: o_valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first low rx_s, ±1 cycle. Add SYNC_STAGES cycles to reference from the raw falling edge.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so a start bit arriving immediately after the stop bit is caught.
  - No inter-frame gap is required.
- Strobe exclusivity: o_valid and o_frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, expecting even parity (XOR of 8 data bits plus parity bit == 0).
  - Adds output o_parity_err (1 bit): a one-cycle strobe at the stop-bit sample cycle when parity failed and the stop bit was good.
  - On parity failure, o_valid is suppressed and o_data is not updated.
  - A frame error takes priority over a parity error.
- Undefined:
  - No PARITY state and no o_parity_err port; frame format is 8N1 only.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - DEFAULT_CLKS_PER_BIT = 868.
  - UART_DATA_BITS = 8, shared with uart_tx.
- Sub-module sync_ff (SYNC_STAGES-deep synchroniser, reset value 1). Reusable for other asynchronous pmod inputs.

Test Plan:
- All tests use CLKS_PER_BIT=16 unless noted.
- Send 0x55 then 0xA3, back-to-back with no gap -> two o_valid pulses; o_data=0x55 then 0xA3; o_frame_err never asserts.
- Low glitch of 5 cycles on an idle line -> FSM returns to IDLE; no o_valid or o_frame_err; o_busy high for 8 cycles (ticks 0-7 of START) only.
- Send 0x3C with stop bit forced low, hold the line low for 40 cycles, then send 0x81 -> one o_frame_err pulse; o_data stays at its previous value during the error; then o_valid with 0x81.
- Assert i_reset at bit 4 of 0xFF, release it, then send 0x12 -> no strobe for 0xFF; all outputs reset to 0; o_valid with 0x12.
- Latency check: falling edge of the start bit for 0x00 to o_valid -> 16/2 + 9*16 + SYNC_STAGES cycles, ±1.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> o_valid with 0x07; send 0x07 with parity bit 0 -> o_parity_err pulse, no o_valid, o_data unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants used by uart_rx and uart_tx.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus from uart_rx to its consumer; o_parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] o_data;
  logic                      o_valid;
  logic                      o_frame_err;
  logic                      o_busy;
`ifdef UART_RX_PARITY_EN
  logic                      o_parity_err;
`endif

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_busy
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_frame_err,
`ifdef UART_RX_PARITY_EN
    input o_parity_err,
`endif
    input o_busy
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous single-bit inputs; resets to 1 so an idle-high line stays idle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling each bit at its centre; define UART_RX_PARITY_EN for an even-parity bit
// between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      i_clock,
  input  logic      i_reset,
  input  logic      i_signal,
  uart_rx_if.master rx_out
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [TICK_W-1:0]         tick;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] data_r;
  logic                      valid_r;
  logic                      frame_err_r;
  logic                      busy_r;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bad;
  logic                      parity_err_r;
`endif

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(i_clock),
    .rst(i_reset),
    .d  (i_signal),
    .q  (rx_s)
  );

  // Returning to IDLE at the stop-bit centre leaves half a bit to catch an immediately following start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      tick        <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            tick   <= '0;
            busy_r <= 1'b1;
          end
        end
        START: begin
          if (tick == HALF_TICK) begin
            tick <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == LAST_TICK) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            tick    <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == LAST_TICK) begin
            parity_bad <= (^shift) ^ rx_s;
            tick       <= '0;
            state      <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick == LAST_TICK) begin
            tick <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (parity_bad) begin
                parity_err_r <= 1'b1;
              end else begin
                data_r  <= shift;
                valid_r <= 1'b1;
              end
`else
              data_r  <= shift;
              valid_r <= 1'b1;
`endif
            end else begin
              frame_err_r <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            tick   <= '0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tick   <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_out.o_data      = data_r;
  assign rx_out.o_valid     = valid_r;
  assign rx_out.o_frame_err = frame_err_r;
  assign rx_out.o_busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign rx_out.o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random frames against a frame-level model; parity tests run
// only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;

  int cycle    = 0;
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] valid_data_q[$];
  int         valid_cycle_q[$];
  logic [7:0] err_data_q[$];
  int         overlap_count = 0;
  int         busy_count    = 0;
`ifdef UART_RX_PARITY_EN
  int         parity_err_count = 0;
`endif

  uart_rx_if rx_bus ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_signal(line),
    .rx_out  (rx_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every strobe with the cycle it appeared in, sampled mid-period.
  always @(negedge clk) begin
    if (rx_bus.o_valid) begin
      valid_data_q.push_back(rx_bus.o_data);
      valid_cycle_q.push_back(cycle);
    end
    if (rx_bus.o_frame_err) err_data_q.push_back(rx_bus.o_data);
    if (rx_bus.o_valid && rx_bus.o_frame_err) overlap_count++;
    if (rx_bus.o_busy) busy_count++;
`ifdef UART_RX_PARITY_EN
    if (rx_bus.o_parity_err) parity_err_count++;
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    line = b;
    step(CPB);
  endtask

  // Even-parity bit: makes the count of ones across data plus parity even.
  function automatic logic even_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2) != 0;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(even_parity(b));
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_parity(input logic [7:0] b, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_bit);
    send_bit(1'b1);
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++;
    if (rx_bus.o_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", rx_bus.o_data);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", rx_bus.o_valid);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_bus.o_frame_err);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", rx_bus.o_busy);
    else n_pass++;
    rst = 1'b0;
    step(2 * CPB);
  endtask

  task automatic test_back_to_back();
    int base  = valid_data_q.size();
    int ebase = err_data_q.size();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    repeat (6) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      step($urandom_range(0, 2 * CPB));
    end
    step(2 * CPB);
    n_checks++;
    if (valid_data_q.size() - base !== exp_q.size())
      $display("[TB] FAIL b2b_count: got %0d expected %0d", valid_data_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < valid_data_q.size()) begin
        n_checks++;
        if (valid_data_q[base + i] !== exp_q[i])
          $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, valid_data_q[base + i], exp_q[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (err_data_q.size() - ebase !== 0)
      $display("[TB] FAIL b2b_frame_err: got %0d pulses expected 0", err_data_q.size() - ebase);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_data !== exp_q[exp_q.size() - 1])
      $display("[TB] FAIL b2b_hold: got %h expected %h", rx_bus.o_data, exp_q[exp_q.size() - 1]);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int base  = valid_data_q.size();
    int ebase = err_data_q.size();
    int bbase = busy_count;
    line = 1'b0;
    step(5);
    line = 1'b1;
    step(40);
    n_checks++;
    if (valid_data_q.size() - base !== 0)
      $display("[TB] FAIL glitch_valid: got %0d pulses expected 0", valid_data_q.size() - base);
    else n_pass++;
    n_checks++;
    if (err_data_q.size() - ebase !== 0)
      $display("[TB] FAIL glitch_frame_err: got %0d pulses expected 0", err_data_q.size() - ebase);
    else n_pass++;
    n_checks++;
    if (busy_count - bbase !== CPB / 2)
      $display("[TB] FAIL glitch_busy_cycles: got %0d expected %0d", busy_count - bbase, CPB / 2);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    logic [7:0] prev = 8'($urandom_range(0, 255));
    int base;
    int ebase;
    send_frame(prev, 1'b1);
    step(CPB);
    base  = valid_data_q.size();
    ebase = err_data_q.size();
    send_frame(8'h3C, 1'b0);
    step(20);
    n_checks++;
    if (rx_bus.o_busy !== 1'b1) $display("[TB] FAIL ferr_busy_low_line: got %b expected 1", rx_bus.o_busy);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_data !== prev) $display("[TB] FAIL ferr_data_held: got %h expected %h", rx_bus.o_data, prev);
    else n_pass++;
    step(20);
    line = 1'b1;
    step(CPB);
    send_frame(8'h81, 1'b1);
    step(2 * CPB);
    n_checks++;
    if (err_data_q.size() - ebase !== 1)
      $display("[TB] FAIL ferr_count: got %0d expected 1", err_data_q.size() - ebase);
    else n_pass++;
    if (err_data_q.size() > ebase) begin
      n_checks++;
      if (err_data_q[ebase] !== prev)
        $display("[TB] FAIL ferr_data_at_err: got %h expected %h", err_data_q[ebase], prev);
      else n_pass++;
    end
    n_checks++;
    if (valid_data_q.size() - base !== 1)
      $display("[TB] FAIL ferr_valid_count: got %0d expected 1", valid_data_q.size() - base);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_data !== 8'h81) $display("[TB] FAIL ferr_next_byte: got %h expected 81", rx_bus.o_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int base  = valid_data_q.size();
    int ebase = err_data_q.size();
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    line = 1'b1;
    step(CPB / 2);
    rst = 1'b1;
    step(2);
    n_checks++;
    if (rx_bus.o_data !== 8'h00) $display("[TB] FAIL midrst_data: got %h expected 00", rx_bus.o_data);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", rx_bus.o_busy);
    else n_pass++;
    rst = 1'b0;
    step(6 * CPB);
    send_frame(8'h12, 1'b1);
    step(2 * CPB);
    n_checks++;
    if (valid_data_q.size() - base !== 1)
      $display("[TB] FAIL midrst_valid_count: got %0d expected 1", valid_data_q.size() - base);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_data !== 8'h12) $display("[TB] FAIL midrst_next_byte: got %h expected 12", rx_bus.o_data);
    else n_pass++;
    n_checks++;
    if (err_data_q.size() - ebase !== 0)
      $display("[TB] FAIL midrst_frame_err: got %0d expected 0", err_data_q.size() - ebase);
    else n_pass++;
  endtask

  task automatic test_latency();
    int base = valid_data_q.size();
    int t0   = cycle;
    int lat;
    int exp_lat = CPB / 2 + (9 + PAR_BITS) * CPB + SYNC;
    send_frame(8'h00, 1'b1);
    step(CPB);
    n_checks++;
    if (valid_data_q.size() - base !== 1) begin
      $display("[TB] FAIL latency_valid_count: got %0d expected 1", valid_data_q.size() - base);
    end else begin
      n_pass++;
      lat = valid_cycle_q[base] - t0;
      n_checks++;
      if (lat < exp_lat - 1 || lat > exp_lat + 1)
        $display("[TB] FAIL latency_cycles: got %0d expected %0d +/-1", lat, exp_lat);
      else n_pass++;
      n_checks++;
      if (valid_data_q[base] !== 8'h00) $display("[TB] FAIL latency_byte: got %h expected 00", valid_data_q[base]);
      else n_pass++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base  = valid_data_q.size();
    int pbase = parity_err_count;
    int exp_good = 0;
    int exp_bad  = 0;
    logic [7:0] last = 8'h07;
    logic [7:0] b;
    logic p;
    send_frame_parity(8'h07, 1'b1);
    step(CPB);
    n_checks++;
    if (rx_bus.o_data !== 8'h07) $display("[TB] FAIL parity_good_byte: got %h expected 07", rx_bus.o_data);
    else n_pass++;
    send_frame_parity(8'h07, 1'b0);
    step(CPB);
    n_checks++;
    if (parity_err_count - pbase !== 1)
      $display("[TB] FAIL parity_err_count: got %0d expected 1", parity_err_count - pbase);
    else n_pass++;
    n_checks++;
    if (valid_data_q.size() - base !== 1)
      $display("[TB] FAIL parity_valid_count: got %0d expected 1", valid_data_q.size() - base);
    else n_pass++;
    base  = valid_data_q.size();
    pbase = parity_err_count;
    repeat (6) begin
      b = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      if (p == even_parity(b)) begin
        exp_good++;
        last = b;
      end else begin
        exp_bad++;
      end
      send_frame_parity(b, p);
    end
    step(CPB);
    n_checks++;
    if (valid_data_q.size() - base !== exp_good)
      $display("[TB] FAIL parity_rand_valid: got %0d expected %0d", valid_data_q.size() - base, exp_good);
    else n_pass++;
    n_checks++;
    if (parity_err_count - pbase !== exp_bad)
      $display("[TB] FAIL parity_rand_err: got %0d expected %0d", parity_err_count - pbase, exp_bad);
    else n_pass++;
    n_checks++;
    if (rx_bus.o_data !== last) $display("[TB] FAIL parity_rand_data: got %h expected %h", rx_bus.o_data, last);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_latency();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (overlap_count !== 0) $display("[TB] FAIL strobe_overlap: got %0d cycles expected 0", overlap_count);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
